// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants, state encoding and select helpers for the demux sequencer
package demux_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
        return msb_first ? SEL_W'(N_CH - 1) : '0;
    endfunction

    function automatic logic [SEL_W-1:0] sel_last(input bit msb_first);
        return msb_first ? '0 : SEL_W'(N_CH - 1);
    endfunction

endpackage

// File: rtl/demux_dwell_cnt.sv
// rtl/demux_dwell_cnt.sv - 4-bit dwell counter with clear and terminal count at DWELL-1
module demux_dwell_cnt #(
    parameter int unsigned DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_tc = (r_cnt == 4'(DWELL - 1));

endmodule

// File: rtl/demux_bit_sequencer.sv
// rtl/demux_bit_sequencer.sv - serialises an 8-bit word onto demux D/S; DEMUX_SEQ_B2B_EN enables back-to-back words
module demux_bit_sequencer
    import demux_pkg::*;
#(
    parameter int unsigned DWELL     = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N_CH-1:0]  in_data,
    output logic             in_ready,
    output logic             D,
    output logic [SEL_W-1:0] S,
    output logic             en,
    output logic             busy,
    output logic             done
);

    localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(MSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_LAST  = sel_last(MSB_FIRST);

    state_t            r_state;
    state_t            w_next_state;
    logic [N_CH-1:0]   r_word;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  w_sel_next;
    logic              r_d;
    logic              r_en;
    logic              r_busy;
    logic              r_done;
    logic              w_tc;
    logic              w_last_step;
    logic              w_accept;
    logic              w_cnt_clr;
    logic              w_cnt_inc;

    assign w_cnt_clr = (r_state == IDLE) || w_tc || w_accept;
    assign w_cnt_inc = (r_state == RUN);

    demux_dwell_cnt #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_tc  (w_tc)
    );

    assign w_last_step = (r_state == RUN) && w_tc && (r_sel == SEL_LAST);

`ifdef DEMUX_SEQ_B2B_EN
    assign in_ready = !rst && ((r_state == IDLE) || w_last_step);
`else
    assign in_ready = !rst && (r_state == IDLE);
`endif

    assign w_accept   = in_valid && in_ready;
    assign w_sel_next = MSB_FIRST ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next_state = RUN;
            RUN:  if (w_last_step && !w_accept) w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // An accept in the final step (back-to-back) takes priority so en never drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_sel  <= SEL_FIRST;
            r_d    <= 1'b0;
            r_en   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last_step;
            if (w_accept) begin
                r_word <= in_data;
                r_sel  <= SEL_FIRST;
                r_d    <= in_data[SEL_FIRST];
                r_en   <= 1'b1;
                r_busy <= 1'b1;
            end else if (w_last_step) begin
                r_en   <= 1'b0;
                r_busy <= 1'b0;
            end else if ((r_state == RUN) && w_tc) begin
                r_sel <= w_sel_next;
                r_d   <= r_word[w_sel_next];
            end
        end
    end

    assign D    = r_d;
    assign S    = r_sel;
    assign en   = r_en;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_demux_bit_sequencer.sv
// tb/tb_demux_bit_sequencer.sv - scoreboard bench over several DWELL/MSB_FIRST instances
module tb_demux_bit_sequencer;
    import demux_pkg::*;

    localparam int NI = 4;

`ifdef DEMUX_SEQ_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    function automatic int dw_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 2;
            default: return 15;
        endcase
    endfunction

    function automatic bit msb_of(input int i);
        return (i == 2);
    endfunction

    typedef struct packed {
        logic       is_done;
        logic       d;
        logic [2:0] s;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       rdy_o  [NI];
    logic       d_o    [NI];
    logic [2:0] s_o    [NI];
    logic       en_o   [NI];
    logic       busy_o [NI];
    logic       done_o [NI];

    exp_t q [NI][$];
    int   checks     = 0;
    int   failures   = 0;
    bit   rst_q      = 1'b1;
    bit   do_final   = 1'b0;
    bit   final_done = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        demux_bit_sequencer #(.DWELL(dw_of(g)), .MSB_FIRST(msb_of(g))) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_data  (in_data),
            .in_ready (rdy_o[g]),
            .D        (d_o[g]),
            .S        (s_o[g]),
            .en       (en_o[g]),
            .busy     (busy_o[g]),
            .done     (done_o[g])
        );
    end

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%h required=%h t=%0t", name, i, act, exp, $time);
        end
    endtask

    // Expected trace of a word: each select step repeated DWELL times, then a done marker.
    task automatic push_word(input int i, input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            int s;
            s = msb_of(i) ? 7 - k : k;
            for (int r = 0; r < dw_of(i); r++) q[i].push_back('{1'b0, w[s], 3'(s)});
        end
        q[i].push_back('{1'b1, 1'b0, 3'd0});
    endtask

    always @(posedge clk) begin
        rst_q = rst;
        for (int i = 0; i < NI; i++)
            if (!rst && in_valid && rdy_o[i]) push_word(i, in_data);
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            logic last;
            logic exp_rdy;
            last = 1'b0;
            if (rst_q) begin
                check("reset_outputs", i, 32'({s_o[i], d_o[i], en_o[i], busy_o[i], done_o[i]}),
                      32'({(msb_of(i) ? 3'd7 : 3'd0), 4'b0000}));
                q[i].delete();
            end else begin
                if (done_o[i]) begin
                    check("done_unexpected", i, 32'(q[i].size() == 0), 32'(0));
                    if (q[i].size() != 0) begin
                        e = q[i].pop_front();
                        check("done_position", i, 32'(e.is_done), 32'(1));
                    end
                end
                if (en_o[i]) begin
                    check("step_unexpected", i, 32'(q[i].size() == 0), 32'(0));
                    if (q[i].size() != 0) begin
                        e = q[i].pop_front();
                        check("step_s_d", i, 32'({1'b0, s_o[i], d_o[i]}), 32'({e.is_done, e.s, e.d}));
                        last = (q[i].size() > 0) && q[i][0].is_done;
                    end
                end
                check("busy_vs_en", i, 32'(busy_o[i]), 32'(en_o[i]));
            end
            exp_rdy = !rst && (!en_o[i] || (B2B && last));
            check("in_ready", i, 32'(rdy_o[i]), 32'(exp_rdy));
            if (do_final && !final_done) check("drain_empty", i, 32'(q[i].size()), 32'(0));
        end
        if (do_final) final_done = 1'b1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic one_word(input logic [7:0] w, input int gap);
        in_valid = 1'b1;
        in_data  = w;
        cyc(1);
        in_valid = 1'b0;
        cyc(gap);
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        one_word(8'hA5, 130);
        one_word(8'h81, 130);
        one_word(8'h0F, 130);
        one_word(8'hFF, 4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        cyc(1);
        in_data  = 8'hC3;
        cyc(20);
        in_valid = 1'b0;
        cyc(130);
        one_word(8'h55, 2);
        in_data = 8'hAA;
        cyc(130);
        repeat (1500) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
            cyc(1);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        cyc(300);
        do_final = 1'b1;
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
